// File: rtl/control_unit_if.sv
// Instruction-field inputs and registered decode outputs of the control unit,
// bundled so the decoder and its driver share one port definition.
interface control_unit_if;
    logic [6:0] opcode;
    logic [2:0] fn3;
    logic [6:0] fn7;
    logic       alu_source;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       reg_write;
    logic [3:0] alu_operation;
    logic       illegal;

    modport master (
        output opcode, fn3, fn7,
        input  alu_source, mem_read, mem_write, mem_to_reg,
        input  branch, reg_write, alu_operation, illegal
    );

    modport slave (
        input  opcode, fn3, fn7,
        output alu_source, mem_read, mem_write, mem_to_reg,
        output branch, reg_write, alu_operation, illegal
    );
endinterface

// File: rtl/control_unit.sv
// RV32I main decoder: turns opcode/funct3/funct7 into datapath controls and an
// illegal flag, all registered with a single cycle of latency.
module control_unit (
    input  logic          clk,
    input  logic          rst_n,
    control_unit_if.slave bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] FN7_BASE  = 7'b0000000;
    localparam logic [6:0] FN7_ALT   = 7'b0100000;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // Control bit order: {alu_source, mem_read, mem_write, mem_to_reg, branch, reg_write}
    localparam logic [5:0] CTRL_LOAD   = 6'b110101;
    localparam logic [5:0] CTRL_STORE  = 6'b101000;
    localparam logic [5:0] CTRL_RTYPE  = 6'b000001;
    localparam logic [5:0] CTRL_ITYPE  = 6'b100001;
    localparam logic [5:0] CTRL_BRANCH = 6'b000010;

    logic [5:0] ctrl_s;
    logic [3:0] alu_op_s;
    logic       legal_s;
    logic [5:0] ctrl_d,   ctrl_q;
    logic [3:0] alu_op_d, alu_op_q;
    logic       illegal_d, illegal_q;

    // Instruction class and ALU op decode; legality is tracked separately.
    always_comb begin
        ctrl_s   = 6'b000000;
        alu_op_s = ALU_AND;
        legal_s  = 1'b0;
        case (bus.opcode)
            OP_LOAD: begin
                ctrl_s   = CTRL_LOAD;
                alu_op_s = ALU_ADD;
                case (bus.fn3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_s = 1'b1;
                    default:                                legal_s = 1'b0;
                endcase
            end
            OP_STORE: begin
                ctrl_s   = CTRL_STORE;
                alu_op_s = ALU_ADD;
                case (bus.fn3)
                    3'b000, 3'b001, 3'b010: legal_s = 1'b1;
                    default:                legal_s = 1'b0;
                endcase
            end
            OP_RTYPE: begin
                ctrl_s = CTRL_RTYPE;
                if (bus.fn7 == FN7_BASE) begin
                    legal_s = 1'b1;
                    case (bus.fn3)
                        3'b000:  alu_op_s = ALU_ADD;
                        3'b001:  alu_op_s = ALU_SLL;
                        3'b010:  alu_op_s = ALU_SLT;
                        3'b011:  alu_op_s = ALU_SLTU;
                        3'b100:  alu_op_s = ALU_XOR;
                        3'b101:  alu_op_s = ALU_SRL;
                        3'b110:  alu_op_s = ALU_OR;
                        default: alu_op_s = ALU_AND;
                    endcase
                end else if (bus.fn7 == FN7_ALT) begin
                    case (bus.fn3)
                        3'b000: begin alu_op_s = ALU_SUB; legal_s = 1'b1; end
                        3'b101: begin alu_op_s = ALU_SRA; legal_s = 1'b1; end
                        default: legal_s = 1'b0;
                    endcase
                end else begin
                    legal_s = 1'b0;
                end
            end
            OP_ITYPE: begin
                ctrl_s  = CTRL_ITYPE;
                legal_s = 1'b1;
                case (bus.fn3)
                    3'b000: alu_op_s = ALU_ADD;
                    3'b010: alu_op_s = ALU_SLT;
                    3'b011: alu_op_s = ALU_SLTU;
                    3'b100: alu_op_s = ALU_XOR;
                    3'b110: alu_op_s = ALU_OR;
                    3'b111: alu_op_s = ALU_AND;
                    3'b001: begin
                        alu_op_s = ALU_SLL;
                        legal_s  = (bus.fn7 == FN7_BASE);
                    end
                    default: begin
                        alu_op_s = (bus.fn7 == FN7_ALT) ? ALU_SRA : ALU_SRL;
                        legal_s  = (bus.fn7 == FN7_BASE) || (bus.fn7 == FN7_ALT);
                    end
                endcase
            end
            OP_BRANCH: begin
                ctrl_s  = CTRL_BRANCH;
                legal_s = 1'b1;
                case (bus.fn3)
                    3'b000, 3'b001: alu_op_s = ALU_SUB;
                    3'b100, 3'b101: alu_op_s = ALU_SLT;
                    3'b110, 3'b111: alu_op_s = ALU_SLTU;
                    default:        legal_s  = 1'b0;
                endcase
            end
            default: legal_s = 1'b0;
        endcase
    end

    // Illegal instructions must produce no side effects, so all controls are masked.
    assign ctrl_d    = legal_s ? ctrl_s   : 6'b000000;
    assign alu_op_d  = legal_s ? alu_op_s : 4'b0000;
    assign illegal_d = ~legal_s;

    // Output registers; reset clears everything including illegal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= 6'b000000;
            alu_op_q  <= 4'b0000;
            illegal_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            alu_op_q  <= alu_op_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.alu_source    = ctrl_q[5];
    assign bus.mem_read      = ctrl_q[4];
    assign bus.mem_write     = ctrl_q[3];
    assign bus.mem_to_reg    = ctrl_q[2];
    assign bus.branch        = ctrl_q[1];
    assign bus.reg_write     = ctrl_q[0];
    assign bus.alu_operation = alu_op_q;
    assign bus.illegal       = illegal_q;
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed vector table, latency/reset sequences and a
// randomized run checked against a mnemonic-level reference model.
module tb_control_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    control_unit_if bus ();

    control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Packed observation: {alu_source, mem_read, mem_write, mem_to_reg, branch, reg_write, alu_op[3:0], illegal}
    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [10:0] exp;
        string       name;
    } vec_t;

    localparam logic [10:0] ZERO    = 11'b000000_0000_0;
    localparam logic [10:0] ILLEGAL = 11'b000000_0000_1;

    function automatic logic [10:0] observed();
        return {bus.alu_source, bus.mem_read, bus.mem_write, bus.mem_to_reg,
                bus.branch, bus.reg_write, bus.alu_operation, bus.illegal};
    endfunction

    // Reference: classify the instruction, look up the mnemonic, then encode.
    function automatic logic [10:0] model(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
        logic [3:0] r_base [8] = '{4'd2, 4'd4, 4'd8, 4'd9, 4'd3, 4'd5, 4'd1, 4'd0};
        logic [3:0] br_ops [8] = '{4'd6, 4'd6, 4'd0, 4'd0, 4'd8, 4'd8, 4'd9, 4'd9};
        logic [5:0] ctrl;
        logic [3:0] alu;
        bit         ok;
        ok = 1'b0; ctrl = 6'd0; alu = 4'd0;
        if (op == 7'd3) begin
            ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            ctrl = 6'b110101; alu = 4'd2;
        end else if (op == 7'd35) begin
            ok = (f3 <= 3'd2);
            ctrl = 6'b101000; alu = 4'd2;
        end else if (op == 7'd51) begin
            ctrl = 6'b000001;
            if (f7 == 7'd0) begin
                ok = 1'b1; alu = r_base[f3];
            end else if (f7 == 7'd32 && f3 == 3'd0) begin
                ok = 1'b1; alu = 4'd6;
            end else if (f7 == 7'd32 && f3 == 3'd5) begin
                ok = 1'b1; alu = 4'd7;
            end else begin
                ok = 1'b0;
            end
        end else if (op == 7'd19) begin
            ctrl = 6'b100001;
            alu = r_base[f3];
            if (f3 == 3'd1)      ok = (f7 == 7'd0);
            else if (f3 == 3'd5) begin
                ok = (f7 == 7'd0) || (f7 == 7'd32);
                if (f7 == 7'd32) alu = 4'd7;
            end else ok = 1'b1;
        end else if (op == 7'd99) begin
            ctrl = 6'b000010;
            alu = br_ops[f3];
            ok = !(f3 == 3'd2 || f3 == 3'd3);
        end else begin
            ok = 1'b0;
        end
        return ok ? {ctrl, alu, 1'b0} : ILLEGAL;
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        @(negedge clk);
        bus.opcode = op;
        bus.fn3    = f3;
        bus.fn7    = f7;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [18];

    initial begin
        vecs[0]  = '{7'b0000011, 3'b000, 7'h00, 11'b110101_0010_0, "load_lw"};
        vecs[1]  = '{7'b0000011, 3'b110, 7'h00, ILLEGAL,           "load_bad_fn3"};
        vecs[2]  = '{7'b0110011, 3'b000, 7'h00, 11'b000001_0010_0, "r_add"};
        vecs[3]  = '{7'b0110011, 3'b000, 7'h20, 11'b000001_0110_0, "r_sub"};
        vecs[4]  = '{7'b0110011, 3'b101, 7'h20, 11'b000001_0111_0, "r_sra"};
        vecs[5]  = '{7'b0110011, 3'b110, 7'h20, ILLEGAL,           "r_bad_alt"};
        vecs[6]  = '{7'b0100011, 3'b010, 7'h00, 11'b101000_0010_0, "store_sw"};
        vecs[7]  = '{7'b0100011, 3'b110, 7'h00, ILLEGAL,           "store_bad_fn3"};
        vecs[8]  = '{7'b0010011, 3'b110, 7'h20, 11'b100001_0001_0, "i_ori_fn7_ignored"};
        vecs[9]  = '{7'b0010011, 3'b101, 7'h20, 11'b100001_0111_0, "i_srai"};
        vecs[10] = '{7'b0010011, 3'b001, 7'h20, ILLEGAL,           "i_bad_slli"};
        vecs[11] = '{7'b1100011, 3'b000, 7'h00, 11'b000010_0110_0, "br_beq"};
        vecs[12] = '{7'b1100011, 3'b111, 7'h00, 11'b000010_1001_0, "br_bgeu"};
        vecs[13] = '{7'b1100011, 3'b010, 7'h00, ILLEGAL,           "br_bad_fn3"};
        vecs[14] = '{7'b0000000, 3'b000, 7'h00, ILLEGAL,           "op_zero"};
        vecs[15] = '{7'b0000011, 3'b101, 7'h7f, 11'b110101_0010_0, "load_fn7_ignored"};
        vecs[16] = '{7'b0110011, 3'b011, 7'h00, 11'b000001_1001_0, "r_sltu"};
        vecs[17] = '{7'b0010011, 3'b101, 7'h00, 11'b100001_0101_0, "i_srli"};

        // Asynchronous reset holds outputs low with no clock edge required.
        bus.opcode = 7'b0000011; bus.fn3 = 3'b000; bus.fn7 = 7'h00;
        #2;
        check("reset_async_initial", observed(), ZERO);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held_over_edges", observed(), ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release_no_edge", observed(), ZERO);
        settle();
        check("first_edge_after_reset", observed(), 11'b110101_0010_0);

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].f3, vecs[i].f7);
            settle();
            check(vecs[i].name, observed(), vecs[i].exp);
        end

        // Latency: a new input must not show until the next rising edge.
        drive(7'b0100011, 3'b000, 7'h00);
        settle();
        drive(7'b0000000, 3'b000, 7'h00);
        #1;
        check("latency_hold", observed(), 11'b101000_0010_0);
        settle();
        check("latency_update", observed(), ILLEGAL);

        // Reset between edges clears a legal decode at once and overrides pending input.
        drive(7'b0000011, 3'b010, 7'h00);
        settle();
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_midstream", observed(), ZERO);
        drive(7'b0110011, 3'b000, 7'h00);
        settle();
        check("reset_blocks_decode", observed(), ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        settle();
        check("decode_after_rerelease", observed(), 11'b000001_0010_0);

        // Randomized run, biased towards the decoded opcodes and funct7 values.
        for (int k = 0; k < 400; k++) begin
            logic [6:0] op;
            logic [6:0] f7;
            logic [2:0] f3;
            logic [6:0] ops [5] = '{7'd3, 7'd35, 7'd51, 7'd19, 7'd99};
            logic [10:0] exp;
            logic [10:0] act;
            op = ($urandom_range(0, 5) == 0) ? 7'($urandom) : ops[$urandom_range(0, 4)];
            f3 = 3'($urandom);
            case ($urandom_range(0, 3))
                0, 1:    f7 = 7'h00;
                2:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            drive(op, f3, f7);
            exp = model(op, f3, f7);
            settle();
            act = observed();
            check($sformatf("rand op=%b f3=%b f7=%b", op, f3, f7), act, exp);
            if (act[9] && act[8]) begin
                check("rand_rd_wr_exclusive", act, ZERO);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
